// File: rtl/tanimoto_pkg.sv
// Shared types and sizing helpers for the tanimoto run sequencer.
// Imported by the interface, the threshold generator and the controller.
package tanimoto_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam int DEF_COEF_WIDTH   = 8;
  localparam int DEF_DRAIN_CYCLES = 64;

  // Threshold BRAM data width: popcount range 0..VECTOR_WIDTH
  function automatic int bram_dw(input int vw);
    return $clog2(vw) + 1;
  endfunction

endpackage

// File: rtl/tanimoto_ctrl_if.sv
// Host, BRAM, FIFO and ID-pair signals of the tanimoto run sequencer.
// master = host/test side, slave = controller side.
interface tanimoto_ctrl_if
  import tanimoto_pkg::*;
#(
  parameter int VECTOR_WIDTH = 920,
  parameter int COEF_WIDTH   = DEF_COEF_WIDTH,
  parameter int VCNT_WIDTH   = 16
) ();

  localparam int CNT_WIDTH = $clog2(VECTOR_WIDTH);
  localparam int DW        = bram_dw(VECTOR_WIDTH);

  logic                  i_Start;
  logic                  i_Abort;
  logic [COEF_WIDTH-1:0] i_Coef;
  logic [VCNT_WIDTH-1:0] i_VecCount;
  logic [CNT_WIDTH-1:0]  o_BRAM_Addr;
  logic [DW-1:0]         o_BRAM_Din;
  logic                  o_BRAM_En;
  logic                  o_BRAM_WrEn;
  logic                  i_FifoEmpty;
  logic                  o_FifoRead;
  logic                  o_Valid;
  logic                  i_Read;
  logic                  i_IDPair_Ready;
  logic                  o_IDPair_Read;
  logic [31:0]           o_PairCount;
  logic                  o_Busy;
  logic                  o_Done;

  modport master (
    output i_Start, i_Abort, i_Coef, i_VecCount,
    output i_FifoEmpty, i_Read, i_IDPair_Ready,
    input  o_BRAM_Addr, o_BRAM_Din, o_BRAM_En, o_BRAM_WrEn,
    input  o_FifoRead, o_Valid, o_IDPair_Read,
    input  o_PairCount, o_Busy, o_Done
  );

  modport slave (
    input  i_Start, i_Abort, i_Coef, i_VecCount,
    input  i_FifoEmpty, i_Read, i_IDPair_Ready,
    output o_BRAM_Addr, o_BRAM_Din, o_BRAM_En, o_BRAM_WrEn,
    output o_FifoRead, o_Valid, o_IDPair_Read,
    output o_PairCount, o_Busy, o_Done
  );

endinterface

// File: rtl/tanimoto_ctrl_threshold_gen.sv
// Running i*Coef accumulator with ceil(acc/2^COEF_WIDTH) output.
// thr for step i is registered together with the BRAM address.
module threshold_gen
  import tanimoto_pkg::*;
#(
  parameter int CNT_WIDTH  = 10,
  parameter int COEF_WIDTH = DEF_COEF_WIDTH
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  clear,
  input  logic                  step,
  input  logic [COEF_WIDTH-1:0] coef,
  output logic [CNT_WIDTH:0]    thr
);

  localparam int AW = CNT_WIDTH + COEF_WIDTH + 1;
  localparam logic [AW-1:0] RND = AW'((1 << COEF_WIDTH) - 1);

  logic [AW-1:0]    acc_q, acc_d, acc_r;
  logic [CNT_WIDTH:0] thr_q, thr_d;

  // step: emit ceil of current acc, then advance by coef
  always_comb begin
    acc_r = acc_q + RND;
    acc_d = acc_q;
    thr_d = thr_q;
    if (clear) begin
      acc_d = '0;
    end else if (step) begin
      acc_d = acc_q + AW'(coef);
      thr_d = acc_r[AW-1:COEF_WIDTH];
    end
  end

  // accumulator and output registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_q <= '0;
      thr_q <= '0;
    end else begin
      acc_q <= acc_d;
      thr_q <= thr_d;
    end
  end

  assign thr = thr_q;

endmodule

// File: rtl/tanimoto_ctrl.sv
// Run sequencer: threshold BRAM load, gated vector stream, drain, done.
// Replaces manual BRAM load and FIFO gating in front of tanimoto_top.
module tanimoto_ctrl
  import tanimoto_pkg::*;
#(
  parameter int VECTOR_WIDTH = 920,
  parameter int COEF_WIDTH   = DEF_COEF_WIDTH,
  parameter int VCNT_WIDTH   = 16,
  parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES
) (
  input logic            clk,
  input logic            rstn,
  tanimoto_ctrl_if.slave bus
);

  localparam int CNT_WIDTH = $clog2(VECTOR_WIDTH);
  localparam int QW        = $clog2(DRAIN_CYCLES) + 1;
  localparam logic [CNT_WIDTH:0] IDX_END = (CNT_WIDTH+1)'(VECTOR_WIDTH);
  localparam logic [QW-1:0]      Q_LAST  = QW'(DRAIN_CYCLES - 1);

  state_t                state_q, state_d;
  logic [CNT_WIDTH:0]    idx_q, idx_d;
  logic [CNT_WIDTH-1:0]  addr_q, addr_d;
  logic                  en_q, en_d;
  logic [COEF_WIDTH-1:0] coef_q, coef_d;
  logic [VCNT_WIDTH-1:0] vcnt_q, vcnt_d;
  logic [VCNT_WIDTH-1:0] wcnt_q, wcnt_d;
  logic [QW-1:0]         qcnt_q, qcnt_d;
  logic [31:0]           pcnt_q, pcnt_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  tg_clear, tg_step;
  logic                  run_gate, rd;
  logic [CNT_WIDTH:0]    thr;

  assign run_gate = (state_q == ST_RUN) & ~bus.i_FifoEmpty;
  assign rd       = run_gate & bus.i_Read;

  // next-state and datapath updates
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    addr_d   = addr_q;
    en_d     = 1'b0;
    coef_d   = coef_q;
    vcnt_d   = vcnt_q;
    wcnt_d   = wcnt_q;
    qcnt_d   = qcnt_q;
    pcnt_d   = pcnt_q;
    done_d   = 1'b0;
    tg_clear = 1'b0;
    tg_step  = 1'b0;
    if (state_q != ST_IDLE && bus.i_IDPair_Ready && pcnt_q != '1)
      pcnt_d = pcnt_q + 32'd1;
    if (bus.i_Abort) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: if (bus.i_Start) begin
          coef_d   = bus.i_Coef;
          vcnt_d   = bus.i_VecCount;
          wcnt_d   = '0;
          pcnt_d   = '0;
          idx_d    = '0;
          tg_clear = 1'b1;
          state_d  = ST_LOAD;
        end
        ST_LOAD: if (idx_q == IDX_END) begin
          qcnt_d  = '0;
          state_d = (vcnt_q == '0) ? ST_DRAIN : ST_RUN;
        end else begin
          en_d    = 1'b1;
          addr_d  = idx_q[CNT_WIDTH-1:0];
          tg_step = 1'b1;
          idx_d   = idx_q + 1'b1;
        end
        ST_RUN: if (rd) begin
          wcnt_d = wcnt_q + 1'b1;
          if (wcnt_q == vcnt_q - 1'b1) begin
            qcnt_d  = '0;
            state_d = ST_DRAIN;
          end
        end
        ST_DRAIN: if (bus.i_IDPair_Ready) begin
          qcnt_d = '0;
        end else if (qcnt_q == Q_LAST) begin
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          qcnt_d = qcnt_q + 1'b1;
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
    busy_d = (state_d != ST_IDLE);
  end

  // FSM state and registered outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      addr_q  <= '0;
      en_q    <= 1'b0;
      coef_q  <= '0;
      vcnt_q  <= '0;
      wcnt_q  <= '0;
      qcnt_q  <= '0;
      pcnt_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      en_q    <= en_d;
      coef_q  <= coef_d;
      vcnt_q  <= vcnt_d;
      wcnt_q  <= wcnt_d;
      qcnt_q  <= qcnt_d;
      pcnt_q  <= pcnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  threshold_gen #(
    .CNT_WIDTH  (CNT_WIDTH),
    .COEF_WIDTH (COEF_WIDTH)
  ) u_thr (
    .clk   (clk),
    .rstn  (rstn),
    .clear (tg_clear),
    .step  (tg_step),
    .coef  (coef_q),
    .thr   (thr)
  );

  assign bus.o_BRAM_Addr   = addr_q;
  assign bus.o_BRAM_Din    = thr;
  assign bus.o_BRAM_En     = en_q;
  assign bus.o_BRAM_WrEn   = en_q;
  assign bus.o_Valid       = run_gate;
  assign bus.o_FifoRead    = rd;
  assign bus.o_IDPair_Read = bus.i_IDPair_Ready;
  assign bus.o_PairCount   = pcnt_q;
  assign bus.o_Busy        = busy_q;
  assign bus.o_Done        = done_q;

endmodule

// File: tb/tb_tanimoto_ctrl.sv
// Directed bench for tanimoto_ctrl: BRAM load values, stream gating,
// drain extension, abort and asynchronous reset.
module tb_tanimoto_ctrl;

  logic clk;
  logic rstn;
  int   n_chk, n_pass, n_fail;
  int   cyc, wr_cnt, rd_cnt, done_cnt, viol, we_err, prr_err;
  int   last_rd_cyc, last_rdy_cyc, done_cyc;
  logic [10:0] mem [0:919];

  tanimoto_ctrl_if #(
    .VECTOR_WIDTH (920),
    .COEF_WIDTH   (8),
    .VCNT_WIDTH   (16)
  ) bus ();

  tanimoto_ctrl #(
    .VECTOR_WIDTH (920),
    .COEF_WIDTH   (8),
    .VCNT_WIDTH   (16),
    .DRAIN_CYCLES (64)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bus.o_BRAM_En) begin
      wr_cnt++;
      if (bus.o_BRAM_Addr < 920) mem[bus.o_BRAM_Addr] = bus.o_BRAM_Din;
    end
    if (bus.o_BRAM_WrEn !== bus.o_BRAM_En) we_err++;
    if (bus.o_FifoRead) begin
      rd_cnt++;
      last_rd_cyc = cyc;
    end
    if (bus.o_FifoRead && bus.i_FifoEmpty) viol++;
    if (bus.o_Done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (bus.i_IDPair_Ready) last_rdy_cyc = cyc;
    if (bus.o_IDPair_Read !== bus.i_IDPair_Ready) prr_err++;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clr();
    wr_cnt = 0; rd_cnt = 0; done_cnt = 0; viol = 0;
    we_err = 0; prr_err = 0;
    last_rd_cyc = 0; last_rdy_cyc = 0; done_cyc = 0;
    for (int i = 0; i < 920; i++) mem[i] = 11'h7ff;
  endtask

  task automatic run(input logic [7:0] coef, input logic [15:0] vc,
                     input bit rnd, input bit inj);
    int k;
    bit got;
    clr();
    bus.i_Coef = coef;
    bus.i_VecCount = vc;
    @(posedge clk); #1 bus.i_Start = 1'b1;
    @(posedge clk); #1 bus.i_Start = 1'b0;
    bus.i_Coef = 8'hAA;
    bus.i_VecCount = 16'd999;
    chk("en_before_first_write", bus.o_BRAM_En, 0);
    @(posedge clk); #1;
    chk("first_en", bus.o_BRAM_En, 1);
    chk("first_addr", bus.o_BRAM_Addr, 0);
    chk("first_din", bus.o_BRAM_Din, 0);
    chk("busy_in_load", bus.o_Busy, 1);
    k = 0;
    got = 0;
    while (k < 4000 && !got) begin
      @(negedge clk);
      if (bus.o_Done) got = 1;
      else begin
        @(posedge clk); #1;
        k++;
        if (rnd) begin
          bus.i_Read = 1'($urandom_range(0, 1));
          bus.i_FifoEmpty = 1'($urandom_range(0, 1));
        end
        if (inj)
          bus.i_IDPair_Ready = (k >= 930 && k < 1430 && (k - 930) % 50 == 0);
      end
    end
    bus.i_IDPair_Ready = 1'b0;
    bus.i_Read = 1'b1;
    bus.i_FifoEmpty = 1'b0;
    chk("done_seen", 32'(got), 1);
    @(posedge clk); #1;
    chk("done_one_cycle", bus.o_Done, 0);
    chk("idle_after_done", bus.o_Busy, 0);
  endtask

  initial begin
    int nz;
    bit found;
    clk = 0; rstn = 0; cyc = 0;
    n_chk = 0; n_pass = 0; n_fail = 0;
    bus.i_Start = 0; bus.i_Abort = 0;
    bus.i_Coef = 0; bus.i_VecCount = 0;
    bus.i_FifoEmpty = 0; bus.i_Read = 1;
    bus.i_IDPair_Ready = 0;
    clr();
    #12;
    chk("rst_addr", bus.o_BRAM_Addr, 0);
    chk("rst_din", bus.o_BRAM_Din, 0);
    chk("rst_en", bus.o_BRAM_En, 0);
    chk("rst_wren", bus.o_BRAM_WrEn, 0);
    chk("rst_valid", bus.o_Valid, 0);
    chk("rst_fiforead", bus.o_FifoRead, 0);
    chk("rst_paircount", bus.o_PairCount, 0);
    chk("rst_busy", bus.o_Busy, 0);
    chk("rst_done", bus.o_Done, 0);
    @(negedge clk) rstn = 1;

    run(8'd128, 16'd4, 0, 0);
    chk("c128_writes", wr_cnt, 920);
    chk("c128_thr0", mem[0], 0);
    chk("c128_thr1", mem[1], 1);
    chk("c128_thr2", mem[2], 1);
    chk("c128_thr3", mem[3], 2);
    chk("c128_thr919", mem[919], 460);
    chk("c128_reads", rd_cnt, 4);
    chk("c128_done_cnt", done_cnt, 1);
    chk("c128_drain_len", done_cyc - last_rd_cyc, 65);
    chk("c128_wren_eq_en", we_err, 0);

    run(8'd255, 16'd4, 0, 0);
    chk("c255_thr919", mem[919], 916);
    chk("c255_thr1", mem[1], 1);

    run(8'd0, 16'd4, 0, 0);
    nz = 0;
    for (int i = 0; i < 920; i++) if (mem[i] !== 11'd0) nz++;
    chk("c0_nonzero_entries", nz, 0);
    chk("c0_writes", wr_cnt, 920);

    run(8'd128, 16'd0, 0, 0);
    chk("vc0_reads", rd_cnt, 0);
    chk("vc0_done_cnt", done_cnt, 1);

    run(8'd100, 16'd10, 1, 0);
    chk("bp_reads", rd_cnt, 10);
    chk("bp_read_while_empty", viol, 0);

    run(8'd128, 16'd0, 0, 1);
    chk("drain_paircount", bus.o_PairCount, 10);
    chk("drain_quiet_len", done_cyc - last_rdy_cyc, 65);
    chk("drain_done_cnt", done_cnt, 1);
    chk("idpair_read_follows", prr_err, 0);

    clr();
    bus.i_Coef = 8'd128;
    bus.i_VecCount = 16'd4;
    @(posedge clk); #1 bus.i_Start = 1'b1;
    @(posedge clk); #1 bus.i_Start = 1'b0;
    found = 0;
    for (int k = 0; k < 2000 && !found; k++) begin
      @(negedge clk);
      if (bus.o_BRAM_En && bus.o_BRAM_Addr == 300) found = 1;
    end
    chk("abort_reached_300", 32'(found), 1);
    @(posedge clk); #1 bus.i_Abort = 1'b1;
    @(posedge clk); #1 bus.i_Abort = 1'b0;
    chk("abort_en_low", bus.o_BRAM_En, 0);
    chk("abort_busy_low", bus.o_Busy, 0);
    repeat (100) @(posedge clk);
    #1 chk("abort_no_done", done_cnt, 0);

    @(posedge clk); #1 begin bus.i_Start = 1'b1; bus.i_Abort = 1'b1; end
    @(posedge clk); #1 begin bus.i_Start = 1'b0; bus.i_Abort = 1'b0; end
    chk("start_abort_busy", bus.o_Busy, 0);
    @(posedge clk); #1 chk("start_abort_en", bus.o_BRAM_En, 0);

    run(8'd128, 16'd4, 0, 0);
    chk("reload_writes", wr_cnt, 920);
    chk("reload_thr919", mem[919], 460);

    bus.i_Coef = 8'd1;
    bus.i_VecCount = 16'd100;
    bus.i_FifoEmpty = 1'b1;
    @(posedge clk); #1 bus.i_Start = 1'b1;
    @(posedge clk); #1 bus.i_Start = 1'b0;
    repeat (10) @(posedge clk);
    #1 bus.i_IDPair_Ready = 1'b1;
    @(posedge clk); #1 bus.i_IDPair_Ready = 1'b0;
    repeat (920) @(posedge clk);
    #1;
    chk("rr_busy", bus.o_Busy, 1);
    chk("rr_paircount", bus.o_PairCount, 1);
    chk("rr_valid_empty", bus.o_Valid, 0);
    bus.i_FifoEmpty = 1'b0;
    #1;
    chk("rr_valid", bus.o_Valid, 1);
    chk("rr_fiforead", bus.o_FifoRead, 1);
    rstn = 1'b0;
    #1;
    chk("rr_fiforead_rst", bus.o_FifoRead, 0);
    chk("rr_valid_rst", bus.o_Valid, 0);
    chk("rr_busy_rst", bus.o_Busy, 0);
    chk("rr_din_rst", bus.o_BRAM_Din, 0);
    chk("rr_addr_rst", bus.o_BRAM_Addr, 0);
    chk("rr_paircount_rst", bus.o_PairCount, 0);
    chk("rr_en_rst", bus.o_BRAM_En, 0);
    @(negedge clk) rstn = 1'b1;
    repeat (3) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/tanimoto_ctrl.md
# tanimoto_ctrl

Run-level sequencer placed in front of `tanimoto_top`. On `i_Start` it fills the threshold BRAM with `ceil(i·Coef/2^COEF_WIDTH)` for every popcount `i`. It then opens the vector stream between the input FIFO and `tanimoto_top` for exactly `i_VecCount` words, drains the ID-pair output, and pulses `o_Done`. It replaces the hand-written BRAM load and FIFO gating currently done by the benches.

## Interface
Parameters:
- `VECTOR_WIDTH`, 920, fingerprint bit count; also the BRAM entry count.
- `CNT_WIDTH`, `$clog2(VECTOR_WIDTH)`, BRAM address width; data width is `CNT_WIDTH+1`.
- `COEF_WIDTH`, 8, Tanimoto coefficient as unsigned fraction `Coef/2^COEF_WIDTH`.
- `VCNT_WIDTH`, 16, width of the bus-word count.
- `VEC_ID_WIDTH`, `$clog2(VECTOR_WIDTH)`, ID width; a pair is `2*VEC_ID_WIDTH`.
- `DRAIN_CYCLES`, 64, quiet cycles required before the run is declared done.

Ports (reset is asynchronous, active-low `rstn`; single clock `clk`):
- `clk` in 1: clock.
- `rstn` in 1: async active-low reset.
- `i_Start` in 1: start request; honoured in IDLE only.
- `i_Abort` in 1: synchronous abort to IDLE from any state.
- `i_Coef` in COEF_WIDTH: coefficient; sampled on the accepted start.
- `i_VecCount` in VCNT_WIDTH: bus words to forward; sampled on the accepted start.
- `o_BRAM_Addr` out CNT_WIDTH: threshold write address.
- `o_BRAM_Din` out CNT_WIDTH+1: threshold value.
- `o_BRAM_En` out 1: BRAM enable.
- `o_BRAM_WrEn` out 1: BRAM write enable.
- `i_FifoEmpty` in 1: input FIFO empty.
- `o_FifoRead` out 1: input FIFO read.
- `o_Valid` out 1: to `tanimoto_top.i_Valid`.
- `i_Read` in 1: from `tanimoto_top.o_Read`.
- `i_IDPair_Ready` in 1: from `tanimoto_top.o_IDPair_Ready`.
- `o_IDPair_Read` out 1: to `tanimoto_top.i_IDPair_Read`.
- `o_PairCount` out 32: ID pairs seen in the current run.
- `o_Busy` out 1: high in any state other than IDLE.
- `o_Done` out 1: one-cycle pulse at the end of a run.

## Operation
- **States:** IDLE → LOAD → RUN → DRAIN → DONE → IDLE.
- **IDLE:** `i_Start` latches `i_Coef` and `i_VecCount`, clears the word counter, accumulator and `o_PairCount`, then goes to LOAD.
- **LOAD:** one write per cycle to addresses `0..VECTOR_WIDTH-1`.
  - Accumulator `acc` has width `CNT_WIDTH+COEF_WIDTH+1`; it starts at 0 and adds `Coef` after each write, so no multiplier is needed.
  - `Din = (acc + 2^COEF_WIDTH - 1) >> COEF_WIDTH`.
  - After the write to address `VECTOR_WIDTH-1`, go to RUN, or straight to DRAIN if `VecCount == 0`.
- **RUN:**
  - `o_Valid = ~i_FifoEmpty`.
  - `o_FifoRead = i_Read & ~i_FifoEmpty`. Both are combinational and forced to 0 outside RUN.
  - Each `o_FifoRead` increments the word counter. The read that brings the counter to `VecCount` moves the FSM to DRAIN, so the gate is closed from the next cycle.
- **DRAIN:**
  - The quiet counter resets on any `i_IDPair_Ready` and otherwise increments.
  - When it reaches `DRAIN_CYCLES-1`, go to DONE.
- **DONE:** `o_Done = 1` for one cycle, then IDLE.
- **ID-pair output (all states):** `o_IDPair_Read = i_IDPair_Ready`, combinational. `o_PairCount` increments on every ready cycle from LOAD through DONE and saturates at all-ones. `o_PairCount` holds its value in IDLE until the next start.
- **Abort:** returns to IDLE next cycle with registered BRAM strobes low. No `o_Done` pulse. BRAM contents are partial and undefined.
- **Ignored:** `i_Start` outside IDLE. `i_Start` together with `i_Abort` in IDLE (abort wins).

## Timing
- **Reset values:** all registered outputs 0; state IDLE; counters 0.
- **BRAM signals:** `o_BRAM_Addr/Din/En/WrEn` are registered.
  - Start accepted at edge 0 → first write (`addr 0`, `Din 0`) visible after edge 1.
  - Last write (`addr VECTOR_WIDTH-1`) visible after edge `VECTOR_WIDTH`.
  - `o_Valid` can assert after edge `VECTOR_WIDTH+1`.
  - `o_BRAM_En` is high only in LOAD; `o_BRAM_WrEn` equals `o_BRAM_En`.
- **Counter width:** the word counter width is VCNT_WIDTH. `VecCount = 2^VCNT_WIDTH-1` is legal; no wrap.
- **DRAIN length:** minimum `DRAIN_CYCLES` cycles after the final read.
- **Mid-run reset:** `rstn` low asynchronously clears all state; the FIFO gate drops immediately.

## Structure
- **`tanimoto_pkg`:** FSM state encoding, default `COEF_WIDTH`/`DRAIN_CYCLES`, and a function computing BRAM data width from `VECTOR_WIDTH`.
- **Sub-module `threshold_gen`:** accumulator plus ceil-shift with `clear`/`step` inputs and registered `thr` output. Reusable by any software-shadow checker.

## Test plan
- **Coef=128, VecCount=4:** BRAM writes `thr[0]=0, thr[1]=1, thr[2]=1, thr[3]=2, thr[919]=460`; exactly 920 writes; exactly 4 FIFO reads; `o_Done` after ≥64 quiet cycles.
- **Coef=255 / Coef=0:** `thr[919]=916`, `thr[1]=1` / all entries 0.
- **VecCount=0:** LOAD goes directly to DRAIN; `o_FifoRead` never asserts; `o_Done` once.
- **Back-pressure:** toggle `i_Read` and `i_FifoEmpty` randomly with VecCount=10 → exactly 10 reads; `o_FifoRead` never high while empty.
- **Drain extension:** inject `i_IDPair_Ready` every 50 cycles for 500 cycles → no `o_Done` until 64 quiet cycles; `o_PairCount` = pulses injected.
- **Abort/reset:** `i_Abort` at address 300 → IDLE, no `o_Done`, new start reloads from address 0. `rstn` low during RUN → all outputs 0 immediately.
